// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and the 2-bit transmitter FSM
// encoding live here so the top, the bench and any checkers agree on them.
package uart_tx_io_pkg;

    // Word offsets inside the IO page (mem_addr[3:2]).
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    // STATUS register bit positions.
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVR   = 3;

    // Transmitter FSM states, one per segment of an 8N1 frame.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // Assemble the STATUS word from its flag bits; all other bits read zero.
    function automatic logic [31:0] pack_status(input logic ovr, input logic empty,
                                                input logic full, input logic busy);
        logic [31:0] w;
        w          = '0;
        w[ST_OVR]  = ovr;
        w[ST_EMPTY] = empty;
        w[ST_FULL] = full;
        w[ST_BUSY] = busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU-side IO bus for the UART transmitter.
// Handshake: there is no valid/ready back-pressure on this bus. A write is a
// single cycle with io_sel & |io_wmask and is always accepted by the bus
// (the block may drop the byte internally and flag overrun). A read is a
// single cycle with io_sel & io_rstrb; io_rdata is valid on the following
// cycle and holds until the next strobed read.
interface uart_tx_io_if;
    logic        io_sel;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wmask;
    logic        io_rstrb;
    logic [31:0] io_rdata;

    // Processor / SOC side.
    modport master (
        output io_sel, io_addr, io_wdata, io_wmask, io_rstrb,
        input  io_rdata
    );

    // UART block side.
    modport slave (
        input  io_sel, io_addr, io_wdata, io_wmask, io_rstrb,
        output io_rdata
    );
endinterface

// File: rtl/uart_tx_io_fifo.sv
// uart_tx_fifo: circular TX byte FIFO used when UART_TX_FIFO_EN is defined.
// Pointers carry one extra bit so full and empty are distinguishable; DEPTH
// must be a power of two (>= 2) so the pointers wrap naturally on depth.
// The caller only pushes when !full and only pops when !empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter on the processor data bus.
// Byte stores to DATA are queued and serialised LSB first onto tx; STATUS
// reports {overrun, empty, full, busy} so firmware can poll before writing.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// otherwise a single holding register (plus valid bit) buffers one byte.
module uart_tx_io
    import uart_tx_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_io_if.slave  bus,
    output logic         tx,
    output logic         tx_busy,
    output uart_state_t  dbg_state
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    uart_state_t state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shifter;
    logic        overrun;
    logic        bit_tick;

    logic        wr_hit;
    logic        rd_hit;
    logic        q_push;
    logic        q_pop;
    logic        q_full;
    logic        q_empty;
    logic [7:0]  q_dout;

    // Only the low byte of a store carries data.
    logic        unused_wdata;
    assign unused_wdata = ^bus.io_wdata[31:8];

    assign wr_hit   = bus.io_sel & (|bus.io_wmask) & (bus.io_addr == UART_REG_DATA);
    assign rd_hit   = bus.io_sel & bus.io_rstrb;
    // Full is the pre-edge value, so a write while full is dropped even if a
    // pop frees a slot on the same edge.
    assign q_push   = wr_hit & ~q_full;
    assign bit_tick = (baud_cnt == LAST_CNT);
    // Pop from IDLE, or at the end of a stop bit to chain frames without a gap.
    assign q_pop    = ~q_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_tick));

    assign dbg_state = state;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .din   (bus.io_wdata[7:0]),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic       hold_valid;
    logic [7:0] hold_data;

    assign q_full  = hold_valid;
    assign q_empty = ~hold_valid;
    assign q_dout  = hold_data;

    // Single-byte holding register; push (needs !valid) and pop (needs valid)
    // can never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (q_push) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.io_wdata[7:0];
        end else if (q_pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Transmit FSM with registered tx/tx_busy; tx follows the state one cycle
    // later, which places the start bit two edges after a write from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shifter  <= 8'h00;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_busy <= (state != S_IDLE) | ~q_empty;
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shifter[0];
                default: tx <= 1'b1;
            endcase

            case (state)
                S_IDLE: begin
                    baud_cnt <= 16'd0;
                    if (q_pop) begin
                        shifter <= q_dout;
                        bit_cnt <= 3'd0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        baud_cnt <= 16'd0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= 16'd0;
                        shifter  <= {1'b0, shifter[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= 16'd0;
                        if (q_pop) begin
                            shifter <= q_dout;
                            bit_cnt <= 3'd0;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Overrun: set by a dropped write, cleared by a STATUS read; set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (wr_hit & q_full) begin
            overrun <= 1'b1;
        end else if (rd_hit & (bus.io_addr == UART_REG_STATUS)) begin
            overrun <= 1'b0;
        end
    end

    // Registered read port: one-cycle latency, holds when no read is strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.io_rdata <= 32'd0;
        end else if (rd_hit) begin
            if (bus.io_addr == UART_REG_STATUS) begin
                bus.io_rdata <= pack_status(overrun, q_empty, q_full, tx_busy);
            end else begin
                bus.io_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io (CLKS_PER_BIT=4). Honours UART_TX_FIFO_EN for the
// queue capacity. The reference model works on frames: each accepted byte
// gets a start-bit time fall = max(previous fall + 10*C, write edge + 2);
// occupancy, busy, STATUS and the tx waveform are derived from those times.
module tb_uart_tx_io;
    import uart_tx_io_pkg::*;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset;
    logic        tx;
    logic        tx_busy;
    uart_state_t dbg_state;

    uart_tx_io_if bus ();

    uart_tx_io #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: accepted bytes with their write edge and start-bit edge.
    logic [7:0]  exp_q[$];
    int          w_q[$];
    int          f_q[$];
    int          last_fall;
    int          cyc;
    logic        exp_ovr;
    logic        exp_tx;
    logic        exp_busy;
    logic        exp_active;
    logic [31:0] exp_rdata;
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model across one clock edge with the given bus inputs.
    task automatic model_edge(input logic rst, input logic sel, input logic [1:0] addr,
                              input logic [7:0] wbyte, input logic [3:0] wmask,
                              input logic rstrb);
        int e, occ, fall, idx;
        bit nonidle, full, empty, wr, rd;
        e = cyc + 1;
        if (rst) begin
            exp_q.delete(); w_q.delete(); f_q.delete();
            last_fall  = -100000;
            exp_ovr    = 1'b0;
            exp_rdata  = 32'd0;
            exp_tx     = 1'b1;
            exp_busy   = 1'b0;
            exp_active = 1'b0;
            cyc = e;
            return;
        end
        while (f_q.size() > 0 && f_q[0] + FRAME <= e - 1) begin
            void'(exp_q.pop_front()); void'(w_q.pop_front()); void'(f_q.pop_front());
        end
        occ = 0; nonidle = 0;
        foreach (f_q[k]) begin
            if (w_q[k] < e && f_q[k] - 1 >= e) occ++;
            if (f_q[k] - 1 < e && e <= f_q[k] - 1 + FRAME) nonidle = 1;
        end
        full  = (occ >= DEPTH);
        empty = (occ == 0);
        wr = sel && (wmask != 4'd0) && (addr == 2'd0);
        rd = sel && rstrb;
        if (rd) exp_rdata = (addr == 2'd1) ? {28'd0, exp_ovr, empty, full, exp_busy} : 32'd0;
        if (wr && full) exp_ovr = 1'b1;
        else if (rd && addr == 2'd1) exp_ovr = 1'b0;
        if (wr && !full) begin
            fall = (last_fall + FRAME > e + 2) ? last_fall + FRAME : e + 2;
            exp_q.push_back(wbyte); w_q.push_back(e); f_q.push_back(fall);
            last_fall = fall;
        end
        exp_busy   = nonidle || !empty;
        exp_tx     = 1'b1;
        exp_active = 1'b0;
        foreach (f_q[k]) begin
            if (f_q[k] <= e && e < f_q[k] + FRAME) begin
                idx = (e - f_q[k]) / C;
                if (idx == 0) exp_tx = 1'b0;
                else if (idx <= 8) exp_tx = exp_q[k][idx-1];
            end
            if (f_q[k] - 1 <= e && e < f_q[k] - 1 + FRAME) exp_active = 1'b1;
        end
        cyc = e;
    endtask

    // Driver: apply inputs at the falling edge, check just after the rising edge.
    task automatic step(input logic rst, input logic sel, input logic [1:0] addr,
                        input logic [7:0] wbyte, input logic [3:0] wmask, input logic rstrb);
        reset        = rst;
        bus.io_sel   = sel;
        bus.io_addr  = addr;
        bus.io_wdata = {24'($urandom), wbyte};
        bus.io_wmask = wmask;
        bus.io_rstrb = rstrb;
        model_edge(rst, sel, addr, wbyte, wmask, rstrb);
        @(posedge clk);
        #1;
        check_eq("tx", 32'(tx), 32'(exp_tx));
        check_eq("tx_busy", 32'(tx_busy), 32'(exp_busy));
        check_eq("io_rdata", bus.io_rdata, exp_rdata);
        check_eq("fsm_active", 32'(dbg_state != S_IDLE), 32'(exp_active));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] b);
        step(1'b0, 1'b1, addr, b, 4'($urandom_range(1, 15)), 1'b0);
    endtask

    task automatic rd(input logic [1:0] addr);
        step(1'b0, 1'b1, addr, 8'h00, 4'd0, 1'b1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_fall = -100000;
        exp_ovr = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0; exp_active = 1'b0; exp_rdata = 32'd0;
        reset = 1'b1;
        bus.io_sel = 1'b0; bus.io_addr = 2'd0; bus.io_wdata = 32'd0;
        bus.io_wmask = 4'd0; bus.io_rstrb = 1'b0;

        // Reset, then STATUS (empty only) and an unselected read that must not update.
        repeat (3) step(1'b1, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
        rd(2'd1);
        idle(1);
        step(1'b0, 1'b0, 2'd1, 8'h00, 4'd0, 1'b1);

        // Single frame from IDLE.
        wr(2'd0, 8'h55);
        idle(50);

        // Back-to-back burst beyond capacity, then STATUS twice.
        for (int i = 0; i < DEPTH + 2; i++) wr(2'd0, 8'(8'h41 + i));
        rd(2'd1);
        rd(2'd1);
        idle(FRAME * (DEPTH + 2) + 10);

        // Second byte during a frame, third write while one is pending.
        wr(2'd0, 8'h12); idle(10);
        wr(2'd0, 8'h34); idle(5);
        wr(2'd0, 8'h56);
        rd(2'd1);
        idle(3 * FRAME + 10);

        // Writes to STATUS and reserved offsets are ignored; reserved reads 0.
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h00);
        rd(2'd2);
        idle(20);

        // Reset in the middle of the data bits.
        wr(2'd0, 8'hA5);
        idle(2 + 4 * C + 1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
        rd(2'd1);
        idle(60);

        // Randomised traffic, sparse then dense writes, rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst, r_sel, r_rstrb;
            logic [1:0] r_addr;
            logic [3:0] r_mask;
            r_rst   = ($urandom_range(0, 799) == 0);
            r_sel   = ($urandom_range(0, 3) != 0);
            r_addr  = 2'($urandom_range(0, 3));
            r_rstrb = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, (i < 1500) ? 11 : 2) == 0) r_mask = 4'($urandom_range(1, 15));
            else r_mask = 4'd0;
            step(r_rst, r_sel, r_addr, 8'($urandom), r_mask, r_rstrb);
        end
        idle(FRAME * (DEPTH + 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
